palette_lookup_arbiter: RTL

//  Shares one 16-entry, 12-bit RGB sprite palette between NUM_REQ pixel requesters
//  (board renderer, cursor overlay, captured-piece tray).
//  - Round-robin grant, one lookup per cycle, 2-stage pipeline.
//  - Returns RGB plus a transparency flag to the granted requester.
//  - Sits between the sprite-index fetch logic and the VGA colour mux.

---
 rtl/palette_lookup_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/palette_lookup_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : palette_lookup_arbiter
// Purpose  : Round-robin shared lookup into a 16-entry 12-bit RGB sprite
//            palette, two-stage pipeline, one lookup per cycle.
// Options  : define PALETTE_WR_EN for a writable palette (cfg_* port).
// Revision : 1.0 - initial release
// ============================================================================
module palette_lookup_arbiter #(
  parameter int         NUM_REQ     = 3,
  parameter logic [3:0] TRANS_INDEX = 4'h0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_index,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [11:0]            rsp_rgb,
  output logic                   rsp_transparent,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_index,
  input  logic [11:0]            cfg_rgb
);

  localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  function automatic logic [11:0] f_default_rgb(input logic [3:0] idx);
    logic [11:0] rgb;
    case (idx)
      4'h0: rgb = 12'hF0F;
      4'h1: rgb = 12'h555;
      4'h2: rgb = 12'hFFF;
      4'h3: rgb = 12'hAAA;
      4'h4: rgb = 12'h101;
      4'h5: rgb = 12'hC0C;
      4'h6: rgb = 12'h606;
      4'h7: rgb = 12'h777;
      4'h8: rgb = 12'hDDD;
      4'h9: rgb = 12'h111;
      4'hA: rgb = 12'h909;
      4'hB: rgb = 12'h404;
      4'hC: rgb = 12'hBBB;
      4'hD: rgb = 12'hE0E;
      4'hE: rgb = 12'h333;
      default: rgb = 12'hEEE;
    endcase
    return rgb;
  endfunction

  logic [c_ptr_w-1:0] r_rr_ptr;
  logic [NUM_REQ-1:0] r_s1_grant;
  logic [3:0]         r_s1_index;

  logic [3:0]         w_idx_arr [NUM_REQ];
  logic [NUM_REQ-1:0] w_grant;
  logic               w_grant_any;
  logic [c_ptr_w-1:0] w_grant_idx;
  logic [3:0]         w_sel_index;
  logic [11:0]        w_rd_rgb;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_idx_arr[g] = req_index[4*g+3:4*g];
  end

  // Scan from rr_ptr with wraparound; first valid requester wins.
  always_comb begin : p_arb
    int j;
    j           = 0;
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_sel_index = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_grant_any && req_valid[c_ptr_w'(j)]) begin
        w_grant_any = 1'b1;
        w_grant_idx = c_ptr_w'(j);
      end
    end
    if (Reset) w_grant_any = 1'b0;
    if (w_grant_any) begin
      w_grant[w_grant_idx] = 1'b1;
      w_sel_index          = w_idx_arr[w_grant_idx];
    end
  end

  assign req_ready = w_grant;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rr_ptr   <= '0;
      r_s1_grant <= '0;
      r_s1_index <= '0;
    end else begin
      r_s1_grant <= w_grant;
      if (w_grant_any) begin
        r_s1_index <= w_sel_index;
        r_rr_ptr   <= (w_grant_idx == c_ptr_w'(NUM_REQ - 1)) ? '0
                                                              : w_grant_idx + c_ptr_w'(1);
      end
    end
  end

`ifdef PALETTE_WR_EN
  logic [11:0] r_palette [16];

  // A write landing in the same cycle as the stage-2 read returns the old entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) r_palette[i] <= f_default_rgb(4'(i));
    end else if (cfg_we) begin
      r_palette[cfg_index] <= cfg_rgb;
    end
  end

  assign w_rd_rgb = r_palette[r_s1_index];
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{cfg_we, cfg_index, cfg_rgb};
  assign w_rd_rgb     = f_default_rgb(r_s1_index);
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rsp_valid       <= '0;
      rsp_rgb         <= 12'h000;
      rsp_transparent <= 1'b0;
    end else begin
      rsp_valid <= r_s1_grant;
      if (|r_s1_grant) begin
        rsp_rgb         <= w_rd_rgb;
        rsp_transparent <= (r_s1_index == TRANS_INDEX);
      end
    end
  end

endmodule
`default_nettype wire
